// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps, leading-zero
// suppression and a one-deep pending buffer that swaps into the display only between frames.
module seg7_scan_ctrl #(
    parameter int ON_CYCLES    = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        lz_en,
    output logic        ack,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam logic [15:0] ON_LAST    = 16'(ON_CYCLES - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    scan_state_t state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        frame_end;

    logic [15:0] shadow, shadow_nxt;
    logic [3:0]  shadow_dp, shadow_dp_nxt;
    logic [15:0] pend;
    logic [3:0]  pend_dp;
    logic        pend_full, pend_full_nxt;
    logic        accept;

    logic [3:0]  nib;
    logic        lead_zero;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;
    logic [3:0]  an_nxt;

    // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            4'hF:    s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan sequencing: BLANK then ON for each digit, frame ends leaving ON of digit 3.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 16'd1;
        frame_end = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = ON;
                    cnt_nxt   = 16'd0;
                end
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    state_nxt = BLANK;
                    cnt_nxt   = 16'd0;
                    idx_nxt   = idx + 2'd1;
                    frame_end = (idx == 2'd3);
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = 16'd0;
                idx_nxt   = 2'd0;
            end
        endcase
    end

    // load/ack: a load seen while pending is empty is captured on that edge and ack
    // is high for the following cycle only; while pending is full load is ignored and
    // the requester must keep it asserted. Pending drains into shadow at frame end.
    always_comb begin
        accept        = load && !pend_full;
        shadow_nxt    = shadow;
        shadow_dp_nxt = shadow_dp;
        pend_full_nxt = pend_full;
        if (frame_end && pend_full) begin
            shadow_nxt    = pend;
            shadow_dp_nxt = pend_dp;
            pend_full_nxt = 1'b0;
        end
        if (accept) begin
            pend_full_nxt = 1'b1;
        end
    end

    // Outputs are precomputed from next-state values so they register in lockstep.
    always_comb begin
        case (idx_nxt)
            2'd0: begin
                nib       = shadow_nxt[3:0];
                lead_zero = 1'b0;
            end
            2'd1: begin
                nib       = shadow_nxt[7:4];
                lead_zero = (shadow_nxt[15:4] == 12'd0);
            end
            2'd2: begin
                nib       = shadow_nxt[11:8];
                lead_zero = (shadow_nxt[15:8] == 8'd0);
            end
            default: begin
                nib       = shadow_nxt[15:12];
                lead_zero = (shadow_nxt[15:12] == 4'd0);
            end
        endcase

        seg_nxt = 7'b1111111;
        dp_nxt  = 1'b1;
        an_nxt  = 4'b1111;
        if (state_nxt == ON) begin
            an_nxt  = ~(4'b0001 << idx_nxt);
            dp_nxt  = ~shadow_dp_nxt[idx_nxt];
            seg_nxt = (lz_en && lead_zero) ? 7'b1111111 : hex_to_seg(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            idx       <= 2'd0;
            cnt       <= 16'd0;
            shadow    <= 16'h0000;
            shadow_dp <= 4'b0000;
            pend      <= 16'h0000;
            pend_dp   <= 4'b0000;
            pend_full <= 1'b0;
            ack       <= 1'b0;
            seg       <= 7'b1111111;
            dp        <= 1'b1;
            an        <= 4'b1111;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            shadow    <= shadow_nxt;
            shadow_dp <= shadow_dp_nxt;
            pend_full <= pend_full_nxt;
            ack       <= accept;
            seg       <= seg_nxt;
            dp        <= dp_nxt;
            an        <= an_nxt;
            if (accept) begin
                pend    <= value;
                pend_dp <= dp_in;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl: a frame-position reference model predicts
// {ack,an,seg,dp} every cycle into a queue that a negedge monitor drains and compares.
module tb_seg7_scan_ctrl;

    localparam int ON_C  = 4;
    localparam int BL_C  = 2;
    localparam int SLOT  = ON_C + BL_C;
    localparam int FRAME = 4 * SLOT;
    localparam int W     = 13;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_en;
    logic        ack;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    seg7_scan_ctrl #(.ON_CYCLES(ON_C), .BLANK_CYCLES(BL_C)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
        .lz_en(lz_en), .ack(ack), .seg(seg), .dp(dp), .an(an)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lit segments per nibble, written as the letter lists of the display datasheet.
    string seg_letters[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                               "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] letters_to_seg(input logic [3:0] n);
        logic [6:0] s;
        string l;
        s = 7'b1111111;
        l = seg_letters[n];
        for (int i = 0; i < l.len(); i++) begin
            int pos;
            pos = int'(l[i]) - 97;
            s[6 - pos] = 1'b0;
        end
        return s;
    endfunction

    // Expected outputs for cycle number c after reset, from its position in the frame.
    function automatic logic [W-1:0] expect_vec(input int c, input logic [15:0] shadow,
                                                input logic [3:0] sdp, input logic lz,
                                                input logic a);
        int p, d, w;
        logic [1:0] dd;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] n;
        p = c % FRAME;
        d = p / SLOT;
        w = p % SLOT;
        dd = 2'(d);
        e_an = 4'b1111;
        e_seg = 7'b1111111;
        e_dp = 1'b1;
        if (w >= BL_C) begin
            e_an = ~(4'b0001 << dd);
            e_dp = ~sdp[dd];
            n = 4'(shadow >> (4 * d));
            if (lz && d > 0 && (shadow >> (4 * d)) == 16'd0) e_seg = 7'b1111111;
            else e_seg = letters_to_seg(n);
        end
        return {a, e_an, e_seg, e_dp};
    endfunction

    // reference model
    initial begin
        int c;
        logic [15:0] m_shadow, m_pend;
        logic [3:0]  m_sdp, m_pdp;
        logic        m_full, m_ack, acc;
        c = 0; m_shadow = 0; m_pend = 0; m_sdp = 0; m_pdp = 0; m_full = 0; m_ack = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                c = 0; m_shadow = 0; m_pend = 0; m_sdp = 0; m_pdp = 0; m_full = 0; m_ack = 0;
            end else begin
                acc = load && !m_full;
                if (((c + 1) % FRAME) == 0 && m_full) begin
                    m_shadow = m_pend;
                    m_sdp    = m_pdp;
                    m_full   = 1'b0;
                end
                if (acc) begin
                    m_pend = value;
                    m_pdp  = dp_in;
                    m_full = 1'b1;
                end
                m_ack = acc;
                c = c + 1;
            end
            exp_q.push_back(expect_vec(c, m_shadow, m_sdp, lz_en, m_ack));
        end
    end

    // scoreboard monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t no expectation queued", $time);
            end else begin
                e = exp_q.pop_front();
                if ({ack, an, seg, dp} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got ack=%b an=%b seg=%b dp=%b want ack=%b an=%b seg=%b dp=%b",
                             $time, ack, an, seg, dp, e[12], e[11:8], e[7:1], e[0]);
                end
            end
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] d);
        int n;
        @(negedge clk);
        value = v;
        dp_in = d;
        load  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 200);
        load = 1'b0;
        if (!ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout value=%h got no ack within %0d cycles", v, n);
        end
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== target && n < 200);
        if (an !== target) begin
            checks++;
            errors++;
            $display("FAIL wait_an got an=%b want an=%b", an, target);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        value = 16'h0000;
        dp_in = 4'b0000;
        load  = 1'b0;
        lz_en = 1'b0;
        idle(3);
        #1 rst_n = 1'b1;

        // power-up scan of zeros
        idle(2 * FRAME);

        // mid-frame load shows only from the next frame
        idle(7);
        send(16'h12AF, 4'b0100);
        idle(2 * FRAME);

        // leading-zero suppression cases
        lz_en = 1'b1;
        send(16'h0070, 4'b0000);
        idle(2 * FRAME);
        send(16'h0000, 4'b1010);
        idle(2 * FRAME);
        send(16'h0100, 4'b0001);
        idle(2 * FRAME);

        // back-to-back loads with load held
        lz_en = 1'b0;
        send(16'h1111, 4'b0000);
        send(16'h2222, 4'b1111);
        idle(3 * FRAME);

        // random traffic, lz_en toggled freely
        for (int i = 0; i < 25; i++) begin
            lz_en = 1'($urandom_range(0, 1));
            send(16'($urandom), 4'($urandom));
            idle($urandom_range(0, 30));
            if ($urandom_range(0, 3) == 0) lz_en = ~lz_en;
            idle($urandom_range(0, 10));
        end
        idle(2 * FRAME);

        // reset during digit 2 with pending full
        lz_en = 1'b0;
        wait_an(4'b1110);
        send(16'hABCD, 4'b1111);
        wait_an(4'b1011);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ack, an, seg, dp} !== {1'b0, 4'b1111, 7'b1111111, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got ack=%b an=%b seg=%b dp=%b want ack=0 an=1111 seg=1111111 dp=1",
                     ack, an, seg, dp);
        end
        idle(3);
        #1 rst_n = 1'b1;
        idle(3 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
